// File: rtl/tv80_bus_resp_if.sv
`default_nettype none
// ============================================================================
// tv80_bus_resp_if : CPU strobes and backend handshake bundle for tv80_bus_resp
// Revision: 1.0
// ============================================================================
interface tv80_bus_resp_if;
  logic [15:0] A;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic [7:0]  dout;
  logic [7:0]  int_vector;
  logic [7:0]  di;
  logic        wait_n;
  logic        be_req;
  logic        be_we;
  logic        be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [7:0]  be_rdata;
  logic        be_ack;
  logic        timeout;

  modport slave (
    input  A, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, dout, int_vector,
           be_rdata, be_ack,
    output di, wait_n, be_req, be_we, be_io, be_addr, be_wdata, timeout
  );

  modport master (
    output A, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, dout, int_vector,
           be_rdata, be_ack,
    input  di, wait_n, be_req, be_we, be_io, be_addr, be_wdata, timeout
  );
endinterface
`default_nettype wire

// File: rtl/tv80_bus_resp.sv
`default_nettype none
// ============================================================================
// tv80_bus_resp : TV80 bus cycle to single-request backend bridge with waits
// Revision: 1.0
// ============================================================================
module tv80_bus_resp #(
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  tv80_bus_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [3:0] MIN_WAIT_C = 4'(MIN_WAIT);

  state_t      state;
  logic        acc;
  logic        acc_q;
  logic        inta;
  logic        inta_q;
  logic        start;
  logic        abandon;
  logic        dropped;
  logic [7:0]  tcnt;
  logic [3:0]  wcnt;
  logic [7:0]  di_q;
  logic        be_req_q;
  logic        be_we_q;
  logic        be_io_q;
  logic [15:0] be_addr_q;
  logic [7:0]  be_wdata_q;
  logic        timeout_q;

  assign acc  = bus.rfsh_n & (~bus.mreq_n | ~bus.iorq_n) & (~bus.rd_n ^ ~bus.wr_n);
  assign inta = ~bus.m1_n & ~bus.iorq_n;
  // Ambiguous strobe combinations and interrupt acknowledge never open a request.
  assign start   = acc & ~acc_q & ~(~bus.mreq_n & ~bus.iorq_n) & ~inta;
  assign dropped = abandon | ~acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc_q      <= 1'b0;
      inta_q     <= 1'b0;
      abandon    <= 1'b0;
      tcnt       <= 8'd0;
      wcnt       <= 4'd0;
      di_q       <= 8'h00;
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_io_q    <= 1'b0;
      be_addr_q  <= 16'h0000;
      be_wdata_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      acc_q     <= acc;
      inta_q    <= inta;
      timeout_q <= 1'b0;
      if (inta && !inta_q) begin
        di_q <= bus.int_vector;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            be_addr_q  <= bus.A;
            be_we_q    <= ~bus.wr_n;
            be_io_q    <= ~bus.iorq_n;
            be_wdata_q <= bus.dout;
            be_req_q   <= 1'b1;
            tcnt       <= 8'd0;
            abandon    <= 1'b0;
            state      <= REQ;
          end else if (state == DONE && !acc) begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (bus.be_ack) begin
            be_req_q <= 1'b0;
            if (dropped) begin
              state <= IDLE;
            end else begin
              if (!be_we_q) begin
                di_q <= bus.be_rdata;
              end
              wcnt  <= MIN_WAIT_C;
              state <= HOLD;
            end
          end else if (tcnt + 8'd1 == TIMEOUT_C) begin
            be_req_q  <= 1'b0;
            timeout_q <= 1'b1;
            if (dropped) begin
              state <= IDLE;
            end else begin
              if (!be_we_q) begin
                di_q <= 8'hFF;
              end
              state <= DONE;
            end
          end else begin
            tcnt    <= tcnt + 8'd1;
            abandon <= dropped;
          end
        end
        HOLD: begin
          if (wcnt == 4'd0) begin
            state <= DONE;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wait is held low in the start cycle itself, before the request registers.
  assign bus.wait_n = ~(reset_n &
                        ((acc & (state == REQ || state == HOLD)) |
                         (start & (state == IDLE || state == DONE))));

  assign bus.di       = di_q;
  assign bus.be_req   = be_req_q;
  assign bus.be_we    = be_we_q;
  assign bus.be_io    = be_io_q;
  assign bus.be_addr  = be_addr_q;
  assign bus.be_wdata = be_wdata_q;
  assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tv80_bus_resp.sv
`default_nettype none
// ============================================================================
// tb_tv80_bus_resp : two instances (MIN_WAIT 0 and 3, TIMEOUT 4) on shared stimulus
// Revision: 1.0
// ============================================================================
module tb_tv80_bus_resp;

  localparam int TO  = 4;
  localparam int MW0 = 0;
  localparam int MW3 = 3;

  typedef struct {
    logic        io;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          ack_at;   // REQ cycle carrying be_ack, 0 = never
    int          wl0;      // wait_n low cycles from first be_req cycle, MIN_WAIT 0
    int          wl3;      // same for MIN_WAIT 3
    int          breq;
    int          to;
    logic [7:0]  di;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] model_di;
  vec_t tbl[6];

  tv80_bus_resp_if bus0();
  tv80_bus_resp_if bus3();

  assign bus3.A          = bus0.A;
  assign bus3.mreq_n     = bus0.mreq_n;
  assign bus3.iorq_n     = bus0.iorq_n;
  assign bus3.rd_n       = bus0.rd_n;
  assign bus3.wr_n       = bus0.wr_n;
  assign bus3.m1_n       = bus0.m1_n;
  assign bus3.rfsh_n     = bus0.rfsh_n;
  assign bus3.dout       = bus0.dout;
  assign bus3.int_vector = bus0.int_vector;
  assign bus3.be_rdata   = bus0.be_rdata;
  assign bus3.be_ack     = bus0.be_ack;

  tv80_bus_resp #(.MIN_WAIT(MW0), .TIMEOUT(TO)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  tv80_bus_resp #(.MIN_WAIT(MW3), .TIMEOUT(TO)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus0.mreq_n = 1'b1;
    bus0.iorq_n = 1'b1;
    bus0.rd_n   = 1'b1;
    bus0.wr_n   = 1'b1;
    bus0.m1_n   = 1'b1;
    bus0.rfsh_n = 1'b1;
    bus0.be_ack = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " di"}, {16'h0, bus0.di, bus3.di}, 32'h0);
    chk({tag, " addr"}, {bus0.be_addr, bus3.be_addr}, 32'h0);
    chk({tag, " wdata"}, {16'h0, bus0.be_wdata, bus3.be_wdata}, 32'h0);
    chk({tag, " req/we/io/to/wait"},
        {22'h0, bus0.be_req, bus0.be_we, bus0.be_io, bus0.timeout, bus0.wait_n,
                bus3.be_req, bus3.be_we, bus3.be_io, bus3.timeout, bus3.wait_n},
        32'b00001_00001);
  endtask

  // Expected outcome of one complete access, from the protocol rules alone.
  function automatic vec_t model(input logic io, input logic wr, input logic [15:0] addr,
                                 input logic [7:0] wd, input logic [7:0] rd,
                                 input int ack_at, input logic [7:0] prev_di);
    vec_t v;
    bit   acked;
    acked    = (ack_at >= 1) && (ack_at <= TO);
    v.io     = io;
    v.wr     = wr;
    v.addr   = addr;
    v.wd     = wd;
    v.rd     = rd;
    v.ack_at = ack_at;
    v.breq   = acked ? ack_at : TO;
    v.wl0    = acked ? ack_at + MW0 + 1 : TO;
    v.wl3    = acked ? ack_at + MW3 + 1 : TO;
    v.to     = acked ? 0 : 1;
    v.di     = wr ? prev_di : (acked ? rd : 8'hFF);
    return v;
  endfunction

  task automatic run_check(input string tag, input vec_t v);
    int wl0, wl3, br0, br3, t0, t3;
    wl0 = 0; wl3 = 0; br0 = 0; br3 = 0; t0 = 0; t3 = 0;
    bus0.A        = v.addr;
    bus0.dout     = v.wd;
    bus0.be_rdata = v.rd;
    bus0.mreq_n   = v.io;
    bus0.iorq_n   = ~v.io;
    bus0.rd_n     = v.wr;
    bus0.wr_n     = ~v.wr;
    #1;
    chk({tag, " start-cycle wait_n"}, {30'h0, bus0.wait_n, bus3.wait_n}, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      bus0.be_ack = (c == v.ack_at);
      @(negedge clk);
      if (bus0.be_req)  br0++;
      if (bus3.be_req)  br3++;
      if (!bus0.wait_n) wl0++;
      if (!bus3.wait_n) wl3++;
      if (bus0.timeout) t0++;
      if (bus3.timeout) t3++;
      if (c == 1) begin
        chk({tag, " be_addr"}, {bus0.be_addr, bus3.be_addr}, {v.addr, v.addr});
        chk({tag, " be_wdata"}, {16'h0, bus0.be_wdata, bus3.be_wdata}, {16'h0, v.wd, v.wd});
        chk({tag, " be_we/io"}, {28'h0, bus0.be_we, bus0.be_io, bus3.be_we, bus3.be_io},
            {28'h0, v.wr, v.io, v.wr, v.io});
      end
    end
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " wait low MIN_WAIT0"}, wl0, v.wl0);
    chk({tag, " wait low MIN_WAIT3"}, wl3, v.wl3);
    chk({tag, " be_req cycles"}, {br0[15:0], br3[15:0]}, {v.breq[15:0], v.breq[15:0]});
    chk({tag, " timeout pulses"}, {t0[15:0], t3[15:0]}, {v.to[15:0], v.to[15:0]});
    chk({tag, " di"}, {16'h0, bus0.di, bus3.di}, {16'h0, v.di, v.di});
  endtask

  task automatic no_req(input string tag, input logic mreq_n, input logic iorq_n,
                        input logic rd_n, input logic wr_n, input logic rfsh_n);
    int bad;
    bad = 0;
    bus0.mreq_n = mreq_n;
    bus0.iorq_n = iorq_n;
    bus0.rd_n   = rd_n;
    bus0.wr_n   = wr_n;
    bus0.rfsh_n = rfsh_n;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus0.be_req || bus3.be_req || !bus0.wait_n || !bus3.wait_n) bad++;
      @(posedge clk); #1;
    end
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " no request / no wait"}, bad, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            io    wr    addr      wd     rd   ack wl0 wl3 breq to  di
    tbl[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 2, 3, 6, 2, 0, 8'hA5};
    tbl[1] = '{1'b1, 1'b1, 16'h0042, 8'h5A, 8'h99, 1, 2, 5, 1, 0, 8'hA5};
    tbl[2] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'h12, 0, 4, 4, 4, 1, 8'hFF};
    tbl[3] = '{1'b1, 1'b0, 16'h00FE, 8'h00, 8'h34, 6, 4, 4, 4, 1, 8'hFF};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 8'hC3, 8'h56, 4, 5, 8, 4, 0, 8'hFF};
    tbl[5] = '{1'b1, 1'b0, 16'h7F00, 8'h00, 8'h3C, 3, 4, 7, 3, 0, 8'h3C};

    reset_n         = 1'b0;
    bus0.A          = 16'h0;
    bus0.dout       = 8'h0;
    bus0.int_vector = 8'h0;
    bus0.be_rdata   = 8'h0;
    set_idle();
    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_check($sformatf("vec%0d", i), tbl[i]);
    model_di = tbl[5].di;

    // Interrupt acknowledge: vector loaded, backend untouched.
    begin
      int bad;
      bad = 0;
      bus0.int_vector = 8'hFE;
      bus0.m1_n   = 1'b0;
      bus0.iorq_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus0.be_req || bus3.be_req || !bus0.wait_n || !bus3.wait_n) bad++;
        @(posedge clk); #1;
      end
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("inta no request / no wait", bad, 0);
      chk("inta di", {16'h0, bus0.di, bus3.di}, 32'h0000_FEFE);
      model_di = 8'hFE;
    end

    // CPU abandons a read while the backend is still busy.
    begin
      int br;
      int wl;
      br = 0;
      wl = 0;
      bus0.A        = 16'h2222;
      bus0.be_rdata = 8'h77;
      bus0.mreq_n   = 1'b0;
      bus0.rd_n     = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          bus0.mreq_n = 1'b1;
          bus0.rd_n   = 1'b1;
        end
        bus0.be_ack = (c == 3);
        @(negedge clk);
        if (bus0.be_req && bus3.be_req) br++;
        if (!bus0.wait_n || !bus3.wait_n) wl++;
      end
      @(posedge clk); #1;
      set_idle();
      chk("abandon be_req cycles", br, 3);
      chk("abandon wait low", wl, 0);
      chk("abandon di kept", {16'h0, bus0.di, bus3.di}, {16'h0, model_di, model_di});
    end

    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                8'($urandom), 8'($urandom), $urandom_range(0, 6), model_di);
      run_check($sformatf("rand%0d", i), v);
      model_di = v.di;
    end

    no_req("mreq+iorq both low", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    no_req("rd+wr both low",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset hits while the request is outstanding; the late ack must be dropped.
    bus0.A      = 16'hBEEF;
    bus0.mreq_n = 1'b0;
    bus0.rd_n   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre-reset be_req", {30'h0, bus0.be_req, bus3.be_req}, 32'h3);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("async reset be_req", {30'h0, bus0.be_req, bus3.be_req}, 32'h0);
    chk("async reset wait_n", {30'h0, bus0.wait_n, bus3.wait_n}, 32'h3);
    set_idle();
    bus0.be_ack = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus0.be_ack = 1'b0;
    @(negedge clk);
    chk_reset("post-reset ack ignored");

    no_req("rfsh gate", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tv80_bus_resp.md
TV80_BUS_RESP -- requirements
Module: tv80_bus_resp

Interface
REQ-001 Parameter MIN_WAIT, default 0: extra wait cycles after be_ack before wait_n releases (0..15).
REQ-002 Parameter TIMEOUT, default 255: cycles in REQ before abort (1..255).
REQ-003 clk  input  1: single clock; every register samples on posedge clk.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 A  input  16: CPU address.
REQ-006 mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  input  1 each: CPU bus strobes, active-low, synchronous to clk.
REQ-007 dout  input  8: CPU write data.
REQ-008 int_vector  input  8: byte returned on interrupt acknowledge.
REQ-009 di  output  8: read data to CPU.
REQ-010 wait_n  output  1: CPU wait request, active-low.
REQ-011 be_req, be_we, be_io  output  1 each: backend request, write flag, I/O-space flag.
REQ-012 be_addr  output  16; be_wdata  output  8: backend address and write data.
REQ-013 be_rdata  input  8; be_ack  input  1: backend read data and single-cycle completion.
REQ-014 timeout  output  1: one-cycle pulse on aborted access.

Function
REQ-015 Access start: posedge where acc = rfsh_n & ((!mreq_n | !iorq_n) & (!rd_n ^ !wr_n)) is 1 and acc was 0 on the previous posedge.
REQ-016 Interrupt acknowledge start: rising edge of (!m1_n & !iorq_n).
- di <= int_vector on that edge.
- No backend request; wait_n stays 1.
REQ-017 Starts while rd_n and wr_n are both low, or while mreq_n and iorq_n are both low, are ignored: no request, state unchanged.
REQ-018 FSM states: IDLE, REQ, HOLD, DONE.
REQ-019 IDLE -> REQ on an access start.
- Capture be_addr = A, be_we = !wr_n, be_io = !iorq_n, be_wdata = dout.
- Assert be_req.
REQ-020 REQ holds be_req = 1 and all be_* fields stable until be_ack.
- On be_ack: drop be_req.
- Read: di <= be_rdata.
- Go to HOLD with wait counter = MIN_WAIT.
REQ-021 HOLD decrements the wait counter each cycle and goes to DONE when it reaches 0; MIN_WAIT = 0 means one HOLD cycle.
REQ-022 DONE -> IDLE on the first posedge with acc = 0.
REQ-023 wait_n is combinational: wait_n = !(acc & (state == REQ | state == HOLD)).
- Also 0 in the start cycle (state == IDLE and access start).
- 1 in all other conditions.
REQ-024 Read latency: be_ack in cycle N -> di valid and wait_n = 1 by cycle N + 1 + MIN_WAIT.
REQ-025 di holds its value until the next read completion or interrupt acknowledge.
REQ-026 Timeout counter clears on entry to REQ and increments each REQ cycle. On reaching TIMEOUT:
- drop be_req;
- for a read, di <= 8'hFF;
- pulse timeout for one cycle;
- go to DONE.
A be_ack in that same cycle wins, and no timeout pulse is generated.
REQ-027 If acc drops during REQ: keep be_req until be_ack or timeout, discard read data, then go to IDLE directly.
REQ-028 be_ack outside REQ is ignored.
REQ-029 Back-to-back accesses: a new start in the same cycle as DONE -> IDLE goes straight to REQ.

Reset
REQ-030 While reset_n = 0: state = IDLE and counters = 0.
REQ-031 Reset values: di = 8'h00, be_req = 0, be_we = 0, be_io = 0, be_addr = 16'h0000, be_wdata = 8'h00, timeout = 0, wait_n = 1.
REQ-032 Reset asserted mid-access: be_req drops immediately (asynchronously); the pending backend ack is then ignored per REQ-028.

Verification
REQ-033 Memory read, MIN_WAIT = 0: A = 16'h1234, mreq_n = rd_n = 0; be_ack with be_rdata = 8'hA5 two cycles after be_req -> be_addr = 16'h1234, be_we = 0, be_io = 0; wait_n low for 3 cycles; di = 8'hA5 next cycle.
REQ-034 I/O write: A = 16'h0042, iorq_n = wr_n = 0, dout = 8'h5A; immediate be_ack -> be_we = 1, be_io = 1, be_wdata = 8'h5A; wait_n low 2 cycles; di unchanged.
REQ-035 MIN_WAIT = 3 read -> wait_n released exactly 4 cycles after the be_ack cycle.
REQ-036 Interrupt ack: m1_n = iorq_n = 0, int_vector = 8'hFE -> di = 8'hFE; no be_req; wait_n stays 1.
REQ-037 TIMEOUT = 4, no be_ack -> be_req high 4 cycles; one timeout pulse; di = 8'hFF; wait_n releases; a late be_ack is ignored.
REQ-038 Reset pulse while in REQ -> be_req = 0 and wait_n = 1 within the reset cycle; rfsh_n = 0 with mreq_n = rd_n = 0 -> no request.
